piso_tx: RTL

//  Parallel-in serial-out transmitter. Sits directly upstream of the sipo

---
 rtl/piso_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word by valid/ready and emits one bit per clock.
// Latency: first bit on serial_out/ser_valid the cycle after accept; all serial outputs are registered.
// Backpressure: in_ready low while a word or idle gap is in flight; zero-bubble reload on the last bit when GAP==0.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_ready,
    output logic             serial_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               serial_out_q, serial_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               word_done_q, word_done_d;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   shreg_shifted;

    assign last_bit = (bit_cnt_q == BIT_LAST);
    assign in_ready = (state_q == S_IDLE) ||
                      ((GAP == 0) && (state_q == S_SHIFT) && last_bit);
    assign accept   = in_valid && in_ready;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_shifted;
                if (!last_bit) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (GAP > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 4'd0;
                end else if (accept) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from next state so they can be registered without adding latency.
        ser_valid_d  = (state_d == S_SHIFT);
        serial_out_d = IDLE_LVL;
        if (ser_valid_d) begin
            serial_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end
        word_done_d  = ser_valid_d && (bit_cnt_d == BIT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= 4'd0;
            serial_out_q <= IDLE_LVL;
            ser_valid_q  <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            serial_out_q <= serial_out_d;
            ser_valid_q  <= ser_valid_d;
            word_done_q  <= word_done_d;
        end
    end

    assign serial_out = serial_out_q;
    assign ser_valid  = ser_valid_q;
    assign word_done  = word_done_q;

endmodule
